top_ddr4_ctrl: RTL and testbench
================================

Name: top_ddr4_ctrl

Overview:
Top-level DDR4 memory block for the TCP/IP datapath. It presents a MIG-style user application interface (app_* command, write-data and read-data channels) over a synthesizable behavioural memory of 512-bit words. It also provides a calibration-complete indication and drives the DDR4 pin bundle to idle/inactive levels.

Parameters:
TCP_DATA_LENGTH, 1456, TCP payload bytes per frame; elaboration check requires MEM_DEPTH >= ceil(TCP_DATA_LENGTH/64) = 23.
MEM_AW, 10, memory word-address width; MEM_DEPTH = 2^MEM_AW words of 512 bits.
CALIB_CYCLES, 1000, clocks from reset release until calibration completes.
RD_LATENCY, 8, clocks from read-command acceptance to rd_data_valid (minimum 1).
FIFO_DEPTH, 4, depth of the write-command FIFO and of the write-data FIFO.

Ports:
CLK_IN_D_0_clk_p  in  1  the single clock; all logic on its rising edge
CLK_IN_D_0_clk_n  in  1  complement of clk_p; used only to drive c0_ddr4_ck_c
sys_rst_n  in  1  asynchronous active-low reset
c0_init_calib_complete  out  1  calibration done, sticky
c0_ddr4_app_en / app_hi_pri  in  1/1  command valid / priority (ignored)
c0_ddr4_app_cmd  in  3  000=write, 001=read, others=no-op
c0_ddr4_app_addr  in  29  word address; bits [MEM_AW-1:0] used
c0_ddr4_app_rdy  out  1  command ready
c0_ddr4_app_wdf_wren / wdf_end  in  1/1  write-data valid / end (ignored)
c0_ddr4_app_wdf_data  in  512  write data
c0_ddr4_app_wdf_mask  in  64  bit i=1 masks byte i
c0_ddr4_app_wdf_rdy  out  1  write-data ready
c0_ddr4_app_rd_data_valid / rd_data_end  out  1/1  read beat valid / last beat
c0_ddr4_app_rd_data  out  512  read data
c0_ddr4_act_n, adr[16:0], ba[1:0], bg[0:0], cke[0:0], odt[0:0], cs_n[0:0], ck_t[0:0], ck_c[0:0], reset_n  out  DDR4 pins
c0_ddr4_dq[63:0], dqs_t[7:0], dqs_c[7:0], dm_dbi_n[7:0]  inout  DDR4 data pins, always high-Z

Behaviour:
- Reset values (sys_rst_n low):
  - calib=0, app_rdy=0, wdf_rdy=0, rd_data_valid=0, rd_data_end=0, rd_data=0.
  - Both FIFOs and the read pipeline are cleared; memory contents are retained.
  - Pins: act_n=1, cs_n=1, adr/ba/bg=0, cke=0, odt=0, reset_n=0.
- Calibration: a counter runs after reset release. c0_init_calib_complete rises after exactly CALIB_CYCLES clocks and then stays 1. cke and reset_n go to 1 with calib.
- Clock pins: ck_t = clk_p, ck_c = clk_n, pass-through.
- wdf_rdy = calib && write-data FIFO not full. Data is pushed when wdf_wren && wdf_rdy; the entry holds data plus mask.
- app_rdy = calib && write-command FIFO not full && (app_cmd != 001 || write-command FIFO empty). app_rdy is combinational on app_cmd. Reads therefore stall until all earlier writes have committed, which guarantees read-after-write ordering.
- Write command: accepted when app_en && app_rdy && cmd=000; the address is pushed to the write-command FIFO. The write commits when both FIFOs are non-empty: unmasked bytes are stored to mem[addr], then both FIFOs pop in the same cycle. Data may arrive before, with, or after its command.
- Read command: accepted when app_en && app_rdy && cmd=001. mem[addr] is sampled at acceptance and delivered RD_LATENCY cycles later with rd_data_valid=rd_data_end=1 for one cycle (single-beat bursts). Back-to-back reads give back-to-back beats. rd_data holds its last value when not valid.
- Other cmd values: accepted (app_rdy as for a write) and have no effect.
- Simultaneous FIFO push and pop in one cycle is allowed; the count is unchanged.
- Asserting reset mid-transfer drops all pending commands and read beats.

Optional Feature:
DDR4_FAST_CALIB_EN
- Defined: c0_init_calib_complete asserts 1 clock after reset release, and CALIB_CYCLES is ignored.
- Not defined: full CALIB_CYCLES delay.

Decomposition:
- Package top_ddr4_pkg: cmd encodings (CMD_WR=3'b000, CMD_RD=3'b001), the 512/64/29 widths, the pin idle constants.
- One sub-module, ddr4_sync_fifo (parameterized width/depth, full/empty), instantiated for the command FIFO (width MEM_AW) and the data FIFO (width 576).

Test Plan:
- Reset release -> calib=0 for CALIB_CYCLES clocks, then 1. app_rdy and wdf_rdy rise with it; cke=1 and reset_n=1.
- Write addr 0..15 with data=i (one per cycle, en and wren together), then read 0..15 -> 16 valid beats, each RD_LATENCY after its command, data=i in order.
- Write addr 5 with data=A, mask=0 and then a second write with data=B, mask=64'hFFFF_FFFF_FFFF_FFFE; read 5 -> byte0=B[7:0], other bytes from A.
- Issue 5 write commands without data -> app_rdy low after 4; a read command stays stalled. Supplying 4 data beats releases both; the read returns the final written data.
- Write data is sent 3 cycles before its command -> commits correctly; wdf_rdy drops once 4 data entries are pending.
- Reset asserted with 2 reads in flight -> no rd_data_valid follows; previously written memory is still readable after re-calibration.

Source files
------------

// File: rtl/top_ddr4_pkg.sv
// top_ddr4_pkg: command encodings, app-interface widths and DDR4 pin idle levels.
package top_ddr4_pkg;
  localparam int DATA_W = 512;
  localparam int MASK_W = 64;
  localparam int ADDR_W = 29;
  typedef enum logic [2:0] {
    CMD_WR = 3'b000,
    CMD_RD = 3'b001
  } app_cmd_e;
  typedef struct packed {
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } wdf_entry_t;
  localparam logic        ACT_N_IDLE = 1'b1;
  localparam logic [0:0]  CS_N_IDLE  = 1'b1;
  localparam logic [16:0] ADR_IDLE   = '0;
  localparam logic [1:0]  BA_IDLE    = '0;
  localparam logic [0:0]  BG_IDLE    = '0;
  localparam logic [0:0]  ODT_IDLE   = '0;
endpackage

// File: rtl/ddr4_sync_fifo.sv
// ddr4_sync_fifo: single-clock FIFO with full/empty; caller gates push/pop.
module ddr4_sync_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = D > 1 ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);
  logic [W-1:0] mem [D];
  logic [PW-1:0] wr, rd;
  logic [CW-1:0] cnt;
  assign full  = cnt == CW'(D);
  assign empty = cnt == '0;
  assign dout  = mem[rd];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else begin
      if (push) wr <= wr == PW'(D - 1) ? '0 : wr + 1'b1;
      if (pop) rd <= rd == PW'(D - 1) ? '0 : rd + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= din;
  end
endmodule

// File: rtl/top_ddr4_ctrl.sv
// top_ddr4_ctrl: MIG-style app interface over a behavioural 512-bit memory; DDR4 pins idle.
// Define DDR4_FAST_CALIB_EN to complete calibration one clock after reset release.
module top_ddr4_ctrl
  import top_ddr4_pkg::*;
#(
  parameter int TCP_DATA_LENGTH = 1456,
  parameter int MEM_AW          = 10,
  parameter int CALIB_CYCLES    = 1000,
  parameter int RD_LATENCY      = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic              CLK_IN_D_0_clk_p,
  input  logic              CLK_IN_D_0_clk_n,
  input  logic              sys_rst_n,
  output logic              c0_init_calib_complete,
  input  logic              c0_ddr4_app_en,
  input  logic              c0_ddr4_app_hi_pri,
  input  logic [2:0]        c0_ddr4_app_cmd,
  input  logic [ADDR_W-1:0] c0_ddr4_app_addr,
  output logic              c0_ddr4_app_rdy,
  input  logic              c0_ddr4_app_wdf_wren,
  input  logic              c0_ddr4_app_wdf_end,
  input  logic [DATA_W-1:0] c0_ddr4_app_wdf_data,
  input  logic [MASK_W-1:0] c0_ddr4_app_wdf_mask,
  output logic              c0_ddr4_app_wdf_rdy,
  output logic              c0_ddr4_app_rd_data_valid,
  output logic              c0_ddr4_app_rd_data_end,
  output logic [DATA_W-1:0] c0_ddr4_app_rd_data,
  output logic              c0_ddr4_act_n,
  output logic [16:0]       c0_ddr4_adr,
  output logic [1:0]        c0_ddr4_ba,
  output logic [0:0]        c0_ddr4_bg,
  output logic [0:0]        c0_ddr4_cke,
  output logic [0:0]        c0_ddr4_odt,
  output logic [0:0]        c0_ddr4_cs_n,
  output logic [0:0]        c0_ddr4_ck_t,
  output logic [0:0]        c0_ddr4_ck_c,
  output logic              c0_ddr4_reset_n,
  inout  wire  [63:0]       c0_ddr4_dq,
  inout  wire  [7:0]        c0_ddr4_dqs_t,
  inout  wire  [7:0]        c0_ddr4_dqs_c,
  inout  wire  [7:0]        c0_ddr4_dm_dbi_n
);
  localparam int MEM_DEPTH = 1 << MEM_AW;
  if (MEM_DEPTH < (TCP_DATA_LENGTH + 63) / 64) begin : g_depth_chk
    $error("MEM_DEPTH too small for one TCP frame");
  end
  logic clk, rst_n, calib;
  assign clk   = CLK_IN_D_0_clk_p;
  assign rst_n = sys_rst_n;
`ifdef DDR4_FAST_CALIB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) calib <= 1'b0;
    else calib <= 1'b1;
  end
`else
  localparam int CW = $clog2(CALIB_CYCLES + 1);
  logic [CW-1:0] cal_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_cnt <= '0;
      calib   <= 1'b0;
    end else if (!calib) begin
      cal_cnt <= cal_cnt + 1'b1;
      calib   <= cal_cnt == CW'(CALIB_CYCLES - 1);
    end
  end
`endif
  logic [MEM_AW-1:0] cf_addr;
  logic cf_push, cf_full, cf_empty, df_push, df_full, df_empty, commit, cmd_acc, rd_acc;
  wdf_entry_t df_in, df_out;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  // Reads wait for an empty command FIFO so they never overtake a pending write.
  assign c0_ddr4_app_rdy     = calib && !cf_full && (c0_ddr4_app_cmd != CMD_RD || cf_empty);
  assign c0_ddr4_app_wdf_rdy = calib && !df_full;
  assign cmd_acc = c0_ddr4_app_en && c0_ddr4_app_rdy;
  assign cf_push = cmd_acc && c0_ddr4_app_cmd == CMD_WR;
  assign rd_acc  = cmd_acc && c0_ddr4_app_cmd == CMD_RD;
  assign df_push = c0_ddr4_app_wdf_wren && c0_ddr4_app_wdf_rdy;
  assign df_in   = '{mask: c0_ddr4_app_wdf_mask, data: c0_ddr4_app_wdf_data};
  assign commit  = !cf_empty && !df_empty;
  ddr4_sync_fifo #(.W(MEM_AW), .D(FIFO_DEPTH)) u_cmd_fifo (
    .clk(clk), .rst_n(rst_n), .push(cf_push), .pop(commit),
    .din(c0_ddr4_app_addr[MEM_AW-1:0]), .dout(cf_addr), .full(cf_full), .empty(cf_empty)
  );
  ddr4_sync_fifo #(.W($bits(wdf_entry_t)), .D(FIFO_DEPTH)) u_data_fifo (
    .clk(clk), .rst_n(rst_n), .push(df_push), .pop(commit),
    .din(df_in), .dout(df_out), .full(df_full), .empty(df_empty)
  );
  always_ff @(posedge clk) begin
    if (commit)
      for (int b = 0; b < MASK_W; b++)
        if (!df_out.mask[b]) mem[cf_addr][b*8 +: 8] <= df_out.data[b*8 +: 8];
  end
  // Each data stage advances only behind a valid beat, so the last stage holds the last delivered word.
  logic [RD_LATENCY-1:0] vpipe;
  logic [DATA_W-1:0] dpipe [RD_LATENCY];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dpipe[i] <= '0;
    end else begin
      vpipe[0] <= rd_acc;
      if (rd_acc) dpipe[0] <= mem[c0_ddr4_app_addr[MEM_AW-1:0]];
      for (int i = 1; i < RD_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
        if (vpipe[i-1]) dpipe[i] <= dpipe[i-1];
      end
    end
  end
  assign c0_ddr4_app_rd_data_valid = vpipe[RD_LATENCY-1];
  assign c0_ddr4_app_rd_data_end   = vpipe[RD_LATENCY-1];
  assign c0_ddr4_app_rd_data       = dpipe[RD_LATENCY-1];
  assign c0_init_calib_complete = calib;
  assign c0_ddr4_act_n   = ACT_N_IDLE;
  assign c0_ddr4_adr     = ADR_IDLE;
  assign c0_ddr4_ba      = BA_IDLE;
  assign c0_ddr4_bg      = BG_IDLE;
  assign c0_ddr4_odt     = ODT_IDLE;
  assign c0_ddr4_cs_n    = CS_N_IDLE;
  assign c0_ddr4_cke     = calib;
  assign c0_ddr4_reset_n = calib;
  assign c0_ddr4_ck_t    = CLK_IN_D_0_clk_p;
  assign c0_ddr4_ck_c    = CLK_IN_D_0_clk_n;
  assign c0_ddr4_dq       = 'z;
  assign c0_ddr4_dqs_t    = 'z;
  assign c0_ddr4_dqs_c    = 'z;
  assign c0_ddr4_dm_dbi_n = 'z;
  logic unused_ok;
  assign unused_ok = ^{c0_ddr4_app_hi_pri, c0_ddr4_app_wdf_end, c0_ddr4_app_addr[ADDR_W-1:MEM_AW]};
endmodule

// File: tb/tb_top_ddr4_ctrl.sv
// tb_top_ddr4_ctrl: directed self-checking bench for top_ddr4_ctrl.
module tb_top_ddr4_ctrl;
`ifdef DDR4_FAST_CALIB_EN
  localparam int CAL = 1;
`else
  localparam int CAL = 1000;
`endif
  localparam int L = 8;
  logic clk_p = 1'b0;
  wire clk_n;
  always #5 clk_p = ~clk_p;
  assign clk_n = ~clk_p;
  logic rst_n, en, hi_pri, wren, wend;
  logic [2:0] cmd;
  logic [28:0] addr;
  logic [511:0] wdata, rd_data;
  logic [63:0] wmask;
  logic calib, app_rdy, wdf_rdy, valid, rend, act_n, dreset_n;
  logic [16:0] adr;
  logic [1:0] ba;
  logic [0:0] bg, cke, odt, cs_n, ck_t, ck_c;
  wire [63:0] dq;
  wire [7:0] dqs_t, dqs_c, dm;
  int pass_cnt = 0, total = 0;
  top_ddr4_ctrl dut (
    .CLK_IN_D_0_clk_p(clk_p), .CLK_IN_D_0_clk_n(clk_n), .sys_rst_n(rst_n),
    .c0_init_calib_complete(calib),
    .c0_ddr4_app_en(en), .c0_ddr4_app_hi_pri(hi_pri), .c0_ddr4_app_cmd(cmd),
    .c0_ddr4_app_addr(addr), .c0_ddr4_app_rdy(app_rdy),
    .c0_ddr4_app_wdf_wren(wren), .c0_ddr4_app_wdf_end(wend),
    .c0_ddr4_app_wdf_data(wdata), .c0_ddr4_app_wdf_mask(wmask), .c0_ddr4_app_wdf_rdy(wdf_rdy),
    .c0_ddr4_app_rd_data_valid(valid), .c0_ddr4_app_rd_data_end(rend), .c0_ddr4_app_rd_data(rd_data),
    .c0_ddr4_act_n(act_n), .c0_ddr4_adr(adr), .c0_ddr4_ba(ba), .c0_ddr4_bg(bg),
    .c0_ddr4_cke(cke), .c0_ddr4_odt(odt), .c0_ddr4_cs_n(cs_n),
    .c0_ddr4_ck_t(ck_t), .c0_ddr4_ck_c(ck_c), .c0_ddr4_reset_n(dreset_n),
    .c0_ddr4_dq(dq), .c0_ddr4_dqs_t(dqs_t), .c0_ddr4_dqs_c(dqs_c), .c0_ddr4_dm_dbi_n(dm)
  );
  function automatic logic [511:0] pat(int s);
    return {16{32'hC0DE0000 | 32'(s)}};
  endfunction
  task automatic read_word(input int a, output logic [511:0] d, output bit ok);
    int n;
    en = 1; cmd = 3'b001; addr = 29'(a); n = 0;
    #1;
    while (!app_rdy && n < 50) begin @(negedge clk_p); #1; n++; end
    ok = app_rdy;
    @(negedge clk_p);
    en = 0; cmd = 3'b000; n = 0;
    while (!valid && n < L + 5) begin @(negedge clk_p); n++; end
    d = rd_data;
    ok = ok && valid;
  endtask
  task automatic test_reset;
    @(negedge clk_p); @(negedge clk_p);
    total++; if ({calib, app_rdy, wdf_rdy} !== 3'b000) begin $display("FAIL reset_rdy got %b want 000", {calib, app_rdy, wdf_rdy}); end else pass_cnt++;
    total++; if ({valid, rend} !== 2'b00 || rd_data !== '0) begin $display("FAIL reset_rd got v=%b e=%b d=%h want 0", valid, rend, rd_data); end else pass_cnt++;
    total++; if ({act_n, cs_n, cke, odt, dreset_n} !== 5'b11000) begin $display("FAIL reset_pins got %b want 11000", {act_n, cs_n, cke, odt, dreset_n}); end else pass_cnt++;
    total++; if ({adr, ba, bg} !== 20'h0) begin $display("FAIL reset_addr_pins got %h want 0", {adr, ba, bg}); end else pass_cnt++;
    total++; if ({ck_t, ck_c} !== 2'b01) begin $display("FAIL ck_pins got %b want 01", {ck_t, ck_c}); end else pass_cnt++;
  endtask
  task automatic test_calib;
    bit early = 0;
    rst_n = 1;
    for (int i = 1; i <= CAL; i++) begin
      @(negedge clk_p);
      if (i < CAL && calib) early = 1;
      if (i == CAL - 1) begin
        total++; if (calib !== 1'b0) begin $display("FAIL calib_before got %b want 0", calib); end else pass_cnt++;
      end
    end
    total++; if (early) begin $display("FAIL calib_early got 1 want 0"); end else pass_cnt++;
    total++; if (calib !== 1'b1) begin $display("FAIL calib_done got %b want 1", calib); end else pass_cnt++;
    total++; if ({app_rdy, wdf_rdy, cke, dreset_n} !== 4'b1111) begin $display("FAIL calib_outs got %b want 1111", {app_rdy, wdf_rdy, cke, dreset_n}); end else pass_cnt++;
  endtask
  task automatic test_seq_write_read;
    for (int i = 0; i < 16; i++) begin
      en = 1; cmd = 3'b000; addr = 29'(i); wren = 1; wdata = 512'(i); wmask = '0;
      #1;
      total++; if ({app_rdy, wdf_rdy} !== 2'b11) begin $display("FAIL seq_wr_rdy[%0d] got %b want 11", i, {app_rdy, wdf_rdy}); end else pass_cnt++;
      @(negedge clk_p);
    end
    en = 0; wren = 0;
    repeat (3) @(negedge clk_p);
    for (int j = 0; j < 16 + L + 2; j++) begin
      bit vexp;
      vexp = j >= L && j - L < 16;
      total++; if ({valid, rend} !== {vexp, vexp}) begin $display("FAIL seq_rd_valid[%0d] got %b%b want %b", j, valid, rend, vexp); end else pass_cnt++;
      if (vexp) begin
        total++; if (rd_data !== 512'(j - L)) begin $display("FAIL seq_rd_data[%0d] got %h want %0d", j, rd_data, j - L); end else pass_cnt++;
      end
      en = j < 16; cmd = 3'b001; addr = 29'(j);
      @(negedge clk_p);
    end
    en = 0; cmd = 3'b000;
  endtask
  task automatic test_mask;
    logic [511:0] a, b, d;
    bit ok;
    a = {16{32'hDEADBEEF}}; b = {16{32'h01234567}};
    en = 1; cmd = 3'b000; addr = 5; wren = 1; wdata = a; wmask = '0;
    @(negedge clk_p);
    wdata = b; wmask = 64'hFFFF_FFFF_FFFF_FFFE;
    @(negedge clk_p);
    en = 0; wren = 0; wmask = '0;
    repeat (2) @(negedge clk_p);
    read_word(5, d, ok);
    total++; if (!ok || d !== {a[511:8], b[7:0]}) begin $display("FAIL mask_rd ok=%b got %h want %h", ok, d, {a[511:8], b[7:0]}); end else pass_cnt++;
  endtask
  task automatic test_stall;
    int n;
    logic [511:0] d;
    for (int k = 0; k < 5; k++) begin
      en = 1; cmd = 3'b000; addr = 29'(100 + k);
      #1;
      total++; if (app_rdy !== (k < 4)) begin $display("FAIL stall_wr_rdy[%0d] got %b want %b", k, app_rdy, k < 4); end else pass_cnt++;
      @(negedge clk_p);
    end
    cmd = 3'b001; addr = 103;
    #1;
    total++; if (app_rdy !== 1'b0) begin $display("FAIL stall_rd_rdy got %b want 0", app_rdy); end else pass_cnt++;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk_p);
      wren = 1; wdata = pat(100 + b); wmask = '0;
      #1;
      total++; if (app_rdy !== 1'b0) begin $display("FAIL stall_rd_held[%0d] got %b want 0", b, app_rdy); end else pass_cnt++;
    end
    @(negedge clk_p);
    wren = 0; n = 0;
    #1;
    while (!app_rdy && n < 10) begin @(negedge clk_p); #1; n++; end
    total++; if (app_rdy !== 1'b1) begin $display("FAIL stall_release got %b want 1", app_rdy); end else pass_cnt++;
    @(negedge clk_p);
    en = 0; cmd = 3'b000; n = 0;
    while (!valid && n < L + 5) begin @(negedge clk_p); n++; end
    d = rd_data;
    total++; if (valid !== 1'b1 || d !== pat(103)) begin $display("FAIL stall_rd_data v=%b got %h want %h", valid, d, pat(103)); end else pass_cnt++;
    @(negedge clk_p);
  endtask
  task automatic test_data_first;
    logic [511:0] d;
    bit ok;
    for (int b = 0; b < 4; b++) begin
      wren = 1; wdata = pat(200 + b); wmask = '0;
      #1;
      total++; if (wdf_rdy !== 1'b1) begin $display("FAIL df_wdf_rdy[%0d] got %b want 1", b, wdf_rdy); end else pass_cnt++;
      @(negedge clk_p);
    end
    wren = 0;
    #1;
    total++; if (wdf_rdy !== 1'b0) begin $display("FAIL df_full got %b want 0", wdf_rdy); end else pass_cnt++;
    repeat (3) @(negedge clk_p);
    for (int k = 0; k < 4; k++) begin
      en = 1; cmd = 3'b000; addr = 29'(200 + k);
      @(negedge clk_p);
    end
    en = 0;
    repeat (2) @(negedge clk_p);
    total++; if (wdf_rdy !== 1'b1) begin $display("FAIL df_drained got %b want 1", wdf_rdy); end else pass_cnt++;
    read_word(202, d, ok);
    total++; if (!ok || d !== pat(202)) begin $display("FAIL df_rd202 ok=%b got %h want %h", ok, d, pat(202)); end else pass_cnt++;
    read_word(200, d, ok);
    total++; if (!ok || d !== pat(200)) begin $display("FAIL df_rd200 ok=%b got %h want %h", ok, d, pat(200)); end else pass_cnt++;
  endtask
  task automatic test_reset_inflight;
    int n;
    bit spur = 0, ok;
    logic [511:0] d;
    @(negedge clk_p);
    en = 1; cmd = 3'b001; addr = 1;
    @(negedge clk_p);
    addr = 2;
    @(negedge clk_p);
    en = 0; cmd = 3'b000;
    @(negedge clk_p);
    rst_n = 0;
    #1;
    total++; if ({valid, calib} !== 2'b00 || rd_data !== '0) begin $display("FAIL rst_mid got v=%b c=%b d=%h want 0", valid, calib, rd_data); end else pass_cnt++;
    @(negedge clk_p);
    rst_n = 1; n = 0;
    while (!calib && n < CAL + 5) begin @(negedge clk_p); n++; if (valid) spur = 1; end
    total++; if (n !== CAL) begin $display("FAIL recal_cycles got %0d want %0d", n, CAL); end else pass_cnt++;
    repeat (L + 2) begin @(negedge clk_p); if (valid) spur = 1; end
    total++; if (spur) begin $display("FAIL rst_dropped got valid=1 want 0"); end else pass_cnt++;
    read_word(7, d, ok);
    total++; if (!ok || d !== 512'd7) begin $display("FAIL retain7 ok=%b got %h want 7", ok, d); end else pass_cnt++;
    read_word(203, d, ok);
    total++; if (!ok || d !== pat(203)) begin $display("FAIL retain203 ok=%b got %h want %h", ok, d, pat(203)); end else pass_cnt++;
  endtask
  initial begin
    rst_n = 0; en = 0; hi_pri = 0; cmd = 3'b000; addr = '0;
    wren = 0; wend = 0; wdata = '0; wmask = '0;
    test_reset;
    test_calib;
    test_seq_write_read;
    test_mask;
    test_stall;
    test_data_first;
    test_reset_inflight;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
